alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports Clk and Reset.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 Req0Valid / Req1Valid  input  1  requester N presents an ALU operation.
REQ-005 Req0Op / Req1Op  input  4  ALU control code from requester N.
REQ-006 Req0A, Req0B / Req1A, Req1B  input  32  operands from requester N.
REQ-007 Req0Ready / Req1Ready  output  1  request N accepted this cycle.
REQ-008 AluControl  output  4  drives ALU32Bit.ALUControl.
REQ-009 AluA, AluB  output  32  drive ALU32Bit.A and ALU32Bit.B.
REQ-010 AluResult  input  32  from ALU32Bit.ALUResult (combinational).
REQ-011 AluZero  input  1  from ALU32Bit.Zero.
REQ-012 RspValid  output  1  response available.
REQ-013 RspId  output  1  requester index owning the response.
REQ-014 RspResult  output  32  registered ALU result.
REQ-015 RspZero  output  1  registered Zero flag.
REQ-016 RspReady  input  1  consumer accepts the response.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-018 IDLE: if any ReqNValid=1, the block SHALL grant one requester, assert its ReqNReady for that cycle only, latch its Op/A/B into internal operand registers, load RspId with its index, and go to EXEC.
REQ-019 IDLE with no valid request SHALL remain in IDLE with both ReqNReady=0.
REQ-020 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last (LastGrant register); with one valid, grant it regardless of LastGrant.
REQ-021 LastGrant SHALL update to the granted index at the grant cycle.
REQ-022 ReqNReady SHALL be 0 in EXEC and RESP, and 0 for the non-granted requester; ReqNReady may depend combinationally on ReqNValid.
REQ-023 AluControl, AluA, AluB SHALL always be driven from the operand registers, never directly from requester inputs; they hold their values outside EXEC.
REQ-024 EXEC: the block SHALL capture AluResult into RspResult and AluZero into RspZero, and go to RESP (one cycle in EXEC).
REQ-025 RESP: RspValid=1; RspId, RspResult and RspZero SHALL be stable until RspValid&RspReady.
REQ-026 On RspValid&RspReady, the block SHALL go to IDLE with RspValid=0 next cycle; a new grant is not possible in the handshake cycle.
REQ-027 Latency: grant at cycle N -> RspValid=1 at cycle N+2; minimum issue interval 3 cycles.
REQ-028 The opcode SHALL be passed through unmodified; unsupported ALU codes are not checked, and whatever the ALU returns is reported.
REQ-029 Requests arriving while not in IDLE SHALL wait; a requester that deasserts valid before grant is dropped without side effect.

Reset
REQ-030 While Reset=1 at a rising edge: state=IDLE, RspValid=0, RspId=0, RspResult=0, RspZero=0, operand registers (AluControl, AluA, AluB)=0, LastGrant=1 (requester 0 wins first tie).
REQ-031 Reset in EXEC or RESP SHALL discard the pending operation; no response is produced for it.
REQ-032 ReqNReady SHALL be 0 in any cycle where Reset=1.

Verification
REQ-033 The bench SHALL instantiate ALU32Bit as the shared datapath, connected through the Alu* ports.
REQ-034 Reset held 2 cycles -> RspValid=0, Req0Ready=Req1Ready=0, AluControl=0, AluA=AluB=0.
REQ-035 Req0 only, Op=2, A=716, B=26, RspReady=1 -> Req0Ready pulses 1 cycle; 2 cycles later RspValid=1, RspId=0, RspResult=742, RspZero=0.
REQ-036 Both valid from reset: Req0 Op=6 A=716 B=26; Req1 Op=0 A=716 B=26 -> first response RspId=0, RspResult=690; second RspId=1, RspResult=8; then Req0 granted again if both remain valid.
REQ-037 Req0 Op=6, A=26, B=26, RspReady=0 for 5 cycles -> RspValid=1, RspResult=0, RspZero=1 held stable; no ReqNReady while held; response released when RspReady=1.
REQ-038 Reset asserted in the EXEC cycle of a Req1 operation -> no response appears; next tie grants Req0.
REQ-039 Req1 Op=15, A=19, B=26 -> RspId=1 and RspResult equal to the ALU32Bit output for those inputs, captured exactly 2 cycles after grant.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: grant, one execute cycle, then hold the response.
module alu_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0Valid,
  input  logic [3:0]  Req0Op,
  input  logic [31:0] Req0A,
  input  logic [31:0] Req0B,
  output logic        Req0Ready,
  input  logic        Req1Valid,
  input  logic [3:0]  Req1Op,
  input  logic [31:0] Req1A,
  input  logic [31:0] Req1B,
  output logic        Req1Ready,
  output logic [3:0]  AluControl,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  input  logic [31:0] AluResult,
  input  logic        AluZero,
  output logic        RspValid,
  output logic        RspId,
  output logic [31:0] RspResult,
  output logic        RspZero,
  input  logic        RspReady
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last_grant;
  logic   idle;
  logic   gnt0;
  logic   gnt1;
  logic   gnt;

  // A tie goes to the requester that was not served last.
  always_comb begin
    idle = (state == IDLE) && !Reset;
    gnt0 = idle && Req0Valid &&
           (!Req1Valid || last_grant);
    gnt1 = idle && Req1Valid &&
           (!Req0Valid || !last_grant);
    gnt  = gnt0 || gnt1;
  end

  assign Req0Ready = gnt0;
  assign Req1Ready = gnt1;
  assign RspValid  = (state == RESP);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (gnt) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: if (RspReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      AluControl <= '0;
      AluA       <= '0;
      AluB       <= '0;
      RspId      <= 1'b0;
      RspResult  <= '0;
      RspZero    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (gnt) begin
        AluControl <= gnt1 ? Req1Op : Req0Op;
        AluA       <= gnt1 ? Req1A : Req0A;
        AluB       <= gnt1 ? Req1B : Req0B;
        RspId      <= gnt1;
        last_grant <= gnt1;
      end
      if (state == EXEC) begin
        RspResult <= AluResult;
        RspZero   <= AluZero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter with a behavioural ALU32Bit on the Alu* ports.
// Responses are checked in order against a queue of expected results.
module tb_alu_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0Valid = 1'b0;
  logic [3:0]  Req0Op = '0;
  logic [31:0] Req0A = '0;
  logic [31:0] Req0B = '0;
  logic        Req0Ready;
  logic        Req1Valid = 1'b0;
  logic [3:0]  Req1Op = '0;
  logic [31:0] Req1A = '0;
  logic [31:0] Req1B = '0;
  logic        Req1Ready;
  logic [3:0]  AluControl;
  logic [31:0] AluA;
  logic [31:0] AluB;
  logic [31:0] AluResult;
  logic        AluZero;
  logic        RspValid;
  logic        RspId;
  logic [31:0] RspResult;
  logic        RspZero;
  logic        RspReady = 1'b1;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        zero;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 Clk = ~Clk;

  alu_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0Op(Req0Op),
    .Req0A(Req0A), .Req0B(Req0B),
    .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Op(Req1Op),
    .Req1A(Req1A), .Req1B(Req1B),
    .Req1Ready(Req1Ready),
    .AluControl(AluControl),
    .AluA(AluA), .AluB(AluB),
    .AluResult(AluResult), .AluZero(AluZero),
    .RspValid(RspValid), .RspId(RspId),
    .RspResult(RspResult), .RspZero(RspZero),
    .RspReady(RspReady)
  );

  function automatic logic [31:0] alu_f(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return {31'd0, $signed(a) < $signed(b)};
      4'd12:   return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  // ALU32Bit stand-in
  always_comb begin
    AluResult = alu_f(AluControl, AluA, AluB);
    AluZero   = (AluResult == 32'd0);
  end

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  function automatic rsp_t mk(
    input logic id,
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    rsp_t r;
    r.id   = id;
    r.res  = alu_f(op, a, b);
    r.zero = (r.res == 32'd0);
    return r;
  endfunction

  always @(negedge Clk) begin
    if (!Reset && RspValid && RspReady) begin
      if (exp_q.size() == 0) begin
        chk("unexp_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", {31'd0, RspId}, {31'd0, e.id});
        chk("rsp_res", RspResult, e.res);
        chk("rsp_zero", {31'd0, RspZero},
            {31'd0, e.zero});
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("rst_r0", {31'd0, Req0Ready}, 32'd0);
    chk("rst_r1", {31'd0, Req1Ready}, 32'd0);
    chk("rst_v", {31'd0, RspValid}, 32'd0);
    chk("rst_ctl", {28'd0, AluControl}, 32'd0);
    chk("rst_a", AluA, 32'd0);
    chk("rst_b", AluB, 32'd0);
    chk("rst_id", {31'd0, RspId}, 32'd0);
    chk("rst_res", RspResult, 32'd0);
    @(posedge Clk);
    #1;
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    Reset = 1'b0;
  endtask

  // Returns one time unit after the grant edge.
  task automatic wait_grant(
    input logic exp_id,
    input string tag
  );
    int n;
    n = 0;
    @(negedge Clk);
    while (!(Req0Ready || Req1Ready) && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 20) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk(tag, {31'd0, Req1Ready}, {31'd0, exp_id});
      chk({tag, "_one"},
          {31'd0, Req0Ready & Req1Ready}, 32'd0);
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    Req0Valid = 1'b1;
    Req1Valid = 1'b1;
    do_reset();

    // single requester, add
    Req0Op = 4'd2; Req0A = 32'd716; Req0B = 32'd26;
    exp_q.push_back(mk(1'b0, 4'd2, 32'd716, 32'd26));
    Req0Valid = 1'b1;
    wait_grant(1'b0, "g_add");
    @(negedge Clk);
    chk("rdy_pulse", {31'd0, Req0Ready}, 32'd0);
    chk("v_exec", {31'd0, RspValid}, 32'd0);
    @(posedge Clk);
    #1 Req0Valid = 1'b0;
    @(negedge Clk);
    chk("lat_add", {31'd0, RspValid}, 32'd1);
    @(posedge Clk);
    @(negedge Clk);
    chk("rel_add", {31'd0, RspValid}, 32'd0);

    // round robin from reset
    do_reset();
    Req0Op = 4'd6; Req0A = 32'd716; Req0B = 32'd26;
    Req1Op = 4'd0; Req1A = 32'd716; Req1B = 32'd26;
    exp_q.push_back(mk(1'b0, 4'd6, 32'd716, 32'd26));
    exp_q.push_back(mk(1'b1, 4'd0, 32'd716, 32'd26));
    exp_q.push_back(mk(1'b0, 4'd6, 32'd716, 32'd26));
    Req0Valid = 1'b1;
    Req1Valid = 1'b1;
    wait_grant(1'b0, "rr_first");
    wait_grant(1'b1, "rr_second");
    wait_grant(1'b0, "rr_third");
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;

    // back-pressure, zero result
    RspReady = 1'b0;
    Req0Op = 4'd6; Req0A = 32'd26; Req0B = 32'd26;
    exp_q.push_back(mk(1'b0, 4'd6, 32'd26, 32'd26));
    Req0Valid = 1'b1;
    wait_grant(1'b0, "g_hold");
    Req0Valid = 1'b0;
    Req1Op = 4'd2; Req1A = 32'd1; Req1B = 32'd2;
    exp_q.push_back(mk(1'b1, 4'd2, 32'd1, 32'd2));
    Req1Valid = 1'b1;
    @(negedge Clk);
    repeat (5) begin
      @(posedge Clk);
      @(negedge Clk);
      chk("hold_v", {31'd0, RspValid}, 32'd1);
      chk("hold_res", RspResult, 32'd0);
      chk("hold_z", {31'd0, RspZero}, 32'd1);
      chk("hold_id", {31'd0, RspId}, 32'd0);
      chk("hold_rdy",
          {31'd0, Req0Ready | Req1Ready}, 32'd0);
    end
    @(posedge Clk);
    #1 RspReady = 1'b1;
    wait_grant(1'b1, "g_after_hold");
    Req1Valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;

    // reset during execute discards the operation
    do_reset();
    Req1Op = 4'd2; Req1A = 32'd5; Req1B = 32'd6;
    Req1Valid = 1'b1;
    wait_grant(1'b1, "g_kill");
    Req1Valid = 1'b0;
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      chk("no_rsp", {31'd0, RspValid}, 32'd0);
    end
    @(posedge Clk);
    #1;
    Req0Op = 4'd2; Req0A = 32'd3; Req0B = 32'd4;
    Req1Op = 4'd0;
    exp_q.push_back(mk(1'b0, 4'd2, 32'd3, 32'd4));
    Req0Valid = 1'b1;
    Req1Valid = 1'b1;
    wait_grant(1'b0, "tie_after_rst");
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    repeat (4) @(posedge Clk);
    #1;

    // unusual opcode passes through
    Req1Op = 4'd15; Req1A = 32'd19; Req1B = 32'd26;
    exp_q.push_back(mk(1'b1, 4'd15, 32'd19, 32'd26));
    Req1Valid = 1'b1;
    wait_grant(1'b1, "g_op15");
    Req1Valid = 1'b0;
    @(negedge Clk);
    chk("op15_ctl", {28'd0, AluControl}, 32'd15);
    chk("op15_a", AluA, 32'd19);
    chk("op15_b", AluB, 32'd26);
    chk("op15_v_exec", {31'd0, RspValid}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    chk("op15_lat", {31'd0, RspValid}, 32'd1);

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
        @(negedge Clk);
        n++;
      end
    end
    chk("drain", exp_q.size(), 32'd0);
    repeat (2) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
